// File: rtl/mem_op_sequencer_if.sv
// Bundle of request, memory-port and operator-port signals between the
// sequencer (master) and the requester/memory/operator environment (slave).
interface mem_op_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);
  logic              start;
  logic              or_mode;
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] b_addr;
  logic [ADDR_W-1:0] c_addr;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic [7:0]        op_count;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              op_mode;
  logic [DATA_W-1:0] op_c;

  modport master (
    input  start, or_mode, a_addr, b_addr, c_addr, mem_rdata, op_c,
    output busy, done, result, op_count, mem_addr, mem_we, mem_wdata,
           op_a, op_b, op_mode
  );

  modport slave (
    output start, or_mode, a_addr, b_addr, c_addr, mem_rdata, op_c,
    input  busy, done, result, op_count, mem_addr, mem_we, mem_wdata,
           op_a, op_b, op_mode
  );
endinterface

// File: rtl/mem_op_sequencer.sv
// Read-read-execute-writeback sequencer: owns the shared operand memory port
// and the registered AND/OR operator inputs for one transaction per start.
module mem_op_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input logic                 clk,
  input logic                 rst,
  mem_op_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_EXEC,
    S_WB,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d;
  logic [ADDR_W-1:0] b_addr_q, b_addr_d;
  logic [ADDR_W-1:0] c_addr_q, c_addr_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [7:0]        op_count_q, op_count_d;

  // Next-state logic; request fields are only latched while idle.
  always_comb begin
    state_d    = state_q;
    a_addr_d   = a_addr_q;
    b_addr_d   = b_addr_q;
    c_addr_d   = c_addr_q;
    mode_d     = mode_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    op_count_d = op_count_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_addr_d = bus.a_addr;
          b_addr_d = bus.b_addr;
          c_addr_d = bus.c_addr;
          mode_d   = bus.or_mode;
          state_d  = S_RD_A;
        end
      end
      S_RD_A: begin
        a_d     = bus.mem_rdata;
        state_d = S_RD_B;
      end
      S_RD_B: begin
        b_d     = bus.mem_rdata;
        state_d = S_EXEC;
      end
      S_EXEC: state_d = S_WB;
      S_WB: begin
        result_d = bus.op_c;
        state_d  = S_DONE;
      end
      S_DONE: begin
        op_count_d = op_count_q + 8'd1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Memory port and status decode; the write is suppressed on a reset edge.
  always_comb begin
    bus.mem_addr = a_addr_q;
    bus.mem_we   = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    case (state_q)
      S_RD_A: bus.busy = 1'b1;
      S_RD_B: begin
        bus.mem_addr = b_addr_q;
        bus.busy     = 1'b1;
      end
      S_EXEC: bus.busy = 1'b1;
      S_WB: begin
        bus.mem_addr = c_addr_q;
        bus.mem_we   = ~rst;
        bus.busy     = 1'b1;
      end
      S_DONE: bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.mem_wdata = bus.op_c;
  assign bus.op_a      = a_q;
  assign bus.op_b      = b_q;
  assign bus.op_mode   = mode_q;
  assign bus.result    = result_q;
  assign bus.op_count  = op_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_addr_q   <= '0;
      b_addr_q   <= '0;
      c_addr_q   <= '0;
      mode_q     <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      a_addr_q   <= a_addr_d;
      b_addr_q   <= b_addr_d;
      c_addr_q   <= c_addr_d;
      mode_q     <= mode_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      op_count_q <= op_count_d;
    end
  end

endmodule

// File: tb/tb_mem_op_sequencer.sv
// Bench for mem_op_sequencer: models the 8-entry bit0-masking memory and the
// registered AND/OR operator, and predicts results from an operand array.
module tb_mem_op_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_op_sequencer_if #(.DATA_W(32), .ADDR_W(3)) bus ();

  mem_op_sequencer #(.DATA_W(32), .ADDR_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Environment: memory with preload port, and the one-cycle operator.
  logic [31:0] mem [8];
  logic        pl_en   = 1'b0;
  logic [2:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  logic [31:0] op_c_q  = '0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata & ~32'h1;
  end
  always @(posedge clk) op_c_q <= bus.op_mode ? (bus.op_a | bus.op_b) : (bus.op_a & bus.op_b);
  assign bus.mem_rdata = mem[bus.mem_addr];
  assign bus.op_c      = op_c_q;

  // Reference state
  logic [31:0] ref_mem [8];
  int          ref_cnt = 0;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [2:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 8; i++) chk(tag, mem[i], ref_mem[i]);
  endtask

  // One transaction; optionally wiggles start/fields while busy.
  task automatic run_txn(input logic m, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] c, input bit glitch);
    logic [31:0] exp_r;
    int k;
    bit seen;
    exp_r = m ? (ref_mem[a] | ref_mem[b]) : (ref_mem[a] & ref_mem[b]);
    bus.start = 1'b1; bus.or_mode = m;
    bus.a_addr = a; bus.b_addr = b; bus.c_addr = c;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.busy) break;
    end
    chk("start_ack", 32'(bus.busy), 32'd1);
    if (!bus.busy) begin
      bus.start = 1'b0;
      return;
    end
    k = 0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (glitch && i < 3) begin
        bus.start  = 1'($urandom_range(0, 1));
        bus.or_mode = 1'($urandom_range(0, 1));
        bus.a_addr = 3'($urandom_range(0, 7));
        bus.b_addr = 3'($urandom_range(0, 7));
        bus.c_addr = 3'($urandom_range(0, 7));
      end else begin
        bus.start = 1'b0;
      end
      tick();
      k = i + 1;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      chk("busy_mid", 32'(bus.busy), 32'd1);
    end
    bus.start = 1'b0;
    chk("done_cycle", seen ? 32'(k + 1) : 32'd0, 32'd5);
    chk("result", bus.result, exp_r);
    ref_mem[c] = exp_r & ~32'h1;
    chk("wb_data", mem[c], ref_mem[c]);
    ref_cnt++;
    tick();
    chk("done_width", 32'(bus.done), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("op_count", 32'(bus.op_count), 32'(ref_cnt % 256));
  endtask

  initial begin
    bus.start = 1'b0; bus.or_mode = 1'b0;
    bus.a_addr = '0; bus.b_addr = '0; bus.c_addr = '0;
    for (int i = 0; i < 8; i++) preload(3'(i), $urandom);
    tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_count", 32'(bus.op_count), 32'd0);
    chk("rst_op_a", bus.op_a, 32'd0);
    chk("rst_op_mode", 32'(bus.op_mode), 32'd0);
    rst = 1'b0;
    tick();

    // Directed AND / OR / aliasing cases
    preload(3'd1, 32'hF0F0F0F3);
    preload(3'd2, 32'h0FF0FF05);
    run_txn(1'b0, 3'd1, 3'd2, 3'd3, 1'b0);
    chk("and_result", bus.result, 32'h00F0F001);
    chk("and_mem", mem[3], 32'h00F0F000);
    chk("and_count", 32'(bus.op_count), 32'd1);
    run_txn(1'b1, 3'd1, 3'd2, 3'd4, 1'b0);
    chk("or_result", bus.result, 32'hFFF0FFF7);
    chk("or_mem", mem[4], 32'hFFF0FFF6);
    preload(3'd1, 32'h12345679);
    run_txn(1'b1, 3'd1, 3'd1, 3'd1, 1'b0);
    chk("alias_result", bus.result, 32'h12345679);
    chk("alias_mem", mem[1], 32'h12345678);
    check_mem("mem_directed");

    // start held high for 20 edges: done at edges 5, 11, 17
    begin
      int nd;
      bit seen;
      logic [31:0] exp_r;
      preload(3'd5, $urandom);
      preload(3'd6, $urandom);
      exp_r = ref_mem[5] | ref_mem[6];
      nd = 0;
      bus.start = 1'b1; bus.or_mode = 1'b1;
      bus.a_addr = 3'd5; bus.b_addr = 3'd6; bus.c_addr = 3'd7;
      for (int e = 1; e <= 20; e++) begin
        tick();
        if (bus.done) begin
          nd++;
          chk("hold_done_edge", 32'(e), 32'(6 * nd - 1));
        end
      end
      chk("hold_done_count", 32'(nd), 32'd3);
      bus.start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (bus.done) begin
          seen = 1'b1;
          break;
        end
      end
      chk("hold_last_done", 32'(seen), 32'd1);
      tick();
      ref_mem[7] = exp_r & ~32'h1;
      ref_cnt += 4;
      chk("hold_result", bus.result, exp_r);
      chk("hold_count", 32'(bus.op_count), 32'(ref_cnt % 256));
      check_mem("mem_hold");
    end

    // Reset while in WB: no write, no done, counter cleared
    begin
      logic [31:0] old6;
      preload(3'd6, 32'hDEADBEEE);
      old6 = mem[6];
      bus.start = 1'b1; bus.or_mode = 1'b1;
      bus.a_addr = 3'd1; bus.b_addr = 3'd2; bus.c_addr = 3'd6;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (bus.busy) break;
      end
      bus.start = 1'b0;
      tick(); tick(); tick();
      chk("wb_we", 32'(bus.mem_we), 32'd1);
      chk("wb_addr", 32'(bus.mem_addr), 32'd6);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstwb_mem", mem[6], old6);
      chk("rstwb_busy", 32'(bus.busy), 32'd0);
      chk("rstwb_done", 32'(bus.done), 32'd0);
      chk("rstwb_count", 32'(bus.op_count), 32'd0);
      tick();
      chk("rstwb_done2", 32'(bus.done), 32'd0);
      ref_cnt = 0;
    end

    // rst and start together: reset wins
    rst = 1'b1; bus.start = 1'b1;
    tick();
    rst = 1'b0; bus.start = 1'b0;
    chk("rst_start_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("rst_start_busy2", 32'(bus.busy), 32'd0);

    // Randomized back-to-back transactions, enough to wrap op_count
    for (int t = 0; t < 260; t++) begin
      if ($urandom_range(0, 3) == 0) preload(3'($urandom_range(0, 7)), $urandom);
      run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), bit'($urandom_range(0, 1)));
      if (t == 255) chk("wrap_count", 32'(bus.op_count), 32'd0);
    end
    check_mem("mem_random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
